// File: rtl/pb_debounce_pkg.sv
// Shared definitions for the pushbutton debounce block.
//   N_BTN_DEFAULT         : default number of button channels
//   cnt_width()           : width of a counter that must reach a given cycle count
//   DEBOUNCE_CNT_W_DEFAULT: stability counter width for the default 12000-cycle window
//   btn_vec_t             : one bit per button at the default channel count
// The optional auto-repeat feature is enabled with PB_DEBOUNCE_AUTOREPEAT_EN.
package pb_debounce_pkg;

  localparam int unsigned N_BTN_DEFAULT = 21;

  // Bits needed to count from 0 up to n without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int unsigned DEBOUNCE_CNT_W_DEFAULT = cnt_width(12000);

  typedef logic [N_BTN_DEFAULT-1:0] btn_vec_t;

endpackage

// File: rtl/pb_debounce_if.sv
// Button bus between the board-side driver and the debounce block.
//   en        : channel-update enable (driver -> debounce)
//   pb_raw    : raw asynchronous buttons, active-high (driver -> debounce)
//   pb_level  : debounced level (debounce -> consumer)
//   pb_rise   : one-cycle accepted-press pulse
//   pb_fall   : one-cycle accepted-release pulse
//   pb_repeat : auto-repeat pulses, 0 unless PB_DEBOUNCE_AUTOREPEAT_EN is defined
// master = side driving en/pb_raw, slave = debounce block.
interface pb_debounce_if
  import pb_debounce_pkg::*;
#(
  parameter int unsigned N = N_BTN_DEFAULT
);
  logic         en;
  logic [N-1:0] pb_raw;
  logic [N-1:0] pb_level;
  logic [N-1:0] pb_rise;
  logic [N-1:0] pb_fall;
  logic [N-1:0] pb_repeat;

  modport master (
    output en, pb_raw,
    input  pb_level, pb_rise, pb_fall, pb_repeat
  );

  modport slave (
    input  en, pb_raw,
    output pb_level, pb_rise, pb_fall, pb_repeat
  );
endinterface

// File: rtl/pb_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, stability counter, debounced level and
// registered press/release pulses. With PB_DEBOUNCE_AUTOREPEAT_EN defined a hold
// counter generates auto-repeat pulses while the button stays pressed.
//   clk, nrst  : clock, asynchronous active-low reset
//   en_i       : update enable; low freezes counters and level, pulses go 0
//   pb_raw_i   : raw asynchronous button
//   level_o    : debounced level
//   rise_o     : one-cycle pulse on accepted press
//   fall_o     : one-cycle pulse on accepted release
//   repeat_o   : auto-repeat pulse (tied 0 without the macro)
module pb_debounce_ch
  import pb_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en_i,
  input  logic pb_raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic repeat_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Synchronizer keeps running while en_i is low so a resumed count sees fresh input.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= pb_raw_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i) begin
      if (s2_q == level_q) begin
        // Any agreeing sample restarts qualification.
        cnt_d = '0;
      end else if (cnt_q == CntLast) begin
        level_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef PB_DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HW = cnt_width(RepMax);
  localparam logic [HW-1:0] DlyLast = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PerLast = HW'(REPEAT_PERIOD - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          armed_q, armed_d;  // first repeat already issued
  logic          rep_q, rep_d;

  always_comb begin
    hold_d  = hold_q;
    armed_d = armed_q;
    rep_d   = 1'b0;
    // An accept edge in either direction restarts the hold window and suppresses
    // a repeat, so repeat never lands on the rise or fall cycle.
    if (!level_q || rise_d || fall_d) begin
      hold_d  = '0;
      armed_d = 1'b0;
    end else if (en_i) begin
      if (hold_q == (armed_q ? PerLast : DlyLast)) begin
        rep_d   = 1'b1;
        hold_d  = '0;
        armed_d = 1'b1;
      end else begin
        hold_d = hold_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_q  <= '0;
      armed_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      armed_q <= armed_d;
      rep_q   <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/pb_debounce.sv
// Pushbutton input conditioning: N_BTN independent debounce channels producing a
// debounced level plus press/release (and optional auto-repeat) pulses.
//   clk   : system clock (hwclk)
//   nrst  : asynchronous active-low reset
//   pb_io : slave side of pb_debounce_if (en, pb_raw in; level/pulses out)
// Optional auto-repeat is enabled by defining PB_DEBOUNCE_AUTOREPEAT_EN.
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 12000,
  parameter int unsigned REPEAT_DELAY    = 6000000,
  parameter int unsigned REPEAT_PERIOD   = 1200000
) (
  input  logic          clk,
  input  logic          nrst,
  pb_debounce_if.slave  pb_io
);

  logic [N_BTN-1:0] level, rise, fall, rpt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    pb_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .nrst     (nrst),
      .en_i     (pb_io.en),
      .pb_raw_i (pb_io.pb_raw[g]),
      .level_o  (level[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g]),
      .repeat_o (rpt[g])
    );
  end

  assign pb_io.pb_level  = level;
  assign pb_io.pb_rise   = rise;
  assign pb_io.pb_fall   = fall;
  assign pb_io.pb_repeat = rpt;

endmodule

// File: doc/pb_debounce.md
Name: pb_debounce

Overview:
- Input-conditioning stage that sits directly upstream of the team design's gpio_in.
- Takes the raw asynchronous board pushbuttons (pb[20:0]) and passes each bit through a 2-flop synchronizer and a per-button stability counter.
- Produces a clean debounced level plus one-cycle press/release pulses that the core consumes in place of raw pb bits.
- Instantiated in the FPGA top on hwclk; reset comes from the same active-low nrst that drives the team design.

Parameters:
- N_BTN, 21, number of button channels.
- DEBOUNCE_CYCLES, 12000, consecutive stable cycles required to accept a new level (1 ms at 12 MHz); legal range >= 1.
- REPEAT_DELAY, 6000000, cycles a button must stay held before the first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  system clock (hwclk).
- nrst  input  1  asynchronous active-low reset.
- en  input  1  channel-update enable; low freezes debounce state.
- pb_raw  input  N_BTN  raw asynchronous buttons, active-high.
- pb_level  output  N_BTN  debounced level.
- pb_rise  output  N_BTN  one-cycle pulse on accepted press.
- pb_fall  output  N_BTN  one-cycle pulse on accepted release.
- pb_repeat  output  N_BTN  auto-repeat pulses; constant 0 without AUTOREPEAT_EN.

Behaviour:
- Reset is asynchronous and active-low on nrst, with one clock, clk. While nrst is low:
  - sync flops, counters and pb_level are 0;
  - pb_rise, pb_fall and pb_repeat are 0.
- Synchronizer:
  - 2 flops per bit (s1, s2); runs whenever nrst is high, independent of en.
- Per-channel debounce (all channels independent and identical):
  - s2 == pb_level: counter cleared to 0.
  - s2 != pb_level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - s2 != pb_level and counter == DEBOUNCE_CYCLES-1: pb_level <= s2 and counter <= 0; pb_rise (new level 1) or pb_fall (new level 0) is high for exactly that next cycle.
- Latency:
  - A clean raw transition present before edge 0 changes pb_level, and fires the pulse, after edge DEBOUNCE_CYCLES+2.
  - With DEBOUNCE_CYCLES=1 this is 3 edges.
- Glitch rejection:
  - Any single cycle with s2 == pb_level during counting clears the counter, so counting restarts from 0.
  - A raw pulse shorter than DEBOUNCE_CYCLES cycles never changes pb_level.
- Counter width is $clog2(DEBOUNCE_CYCLES+1); the counter never wraps.
- en low:
  - counters and pb_level hold; pb_rise, pb_fall and pb_repeat are forced 0.
  - When en returns high, counting resumes from the held value.
- Pulses are registered outputs. rise and fall of the same channel are never high together.
- Reset mid-count:
  - all state returns to 0 immediately;
  - a button held through reset deasserts then re-qualifies after DEBOUNCE_CYCLES+2 edges and gives a fresh pb_rise.

Optional Feature:
- Macro: PB_DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Each channel has a hold counter that runs while pb_level=1 and en=1, and is cleared on pb_fall or when pb_level=0.
  - First pb_repeat pulse fires REPEAT_DELAY cycles after the pb_rise cycle.
  - Further pulses then fire every REPEAT_PERIOD cycles until release.
  - pb_repeat is never coincident with pb_rise.
- Undefined:
  - pb_repeat is tied to 0 and no hold counters are synthesized.
  - REPEAT_* parameters are ignored.

Decomposition:
- Package pb_debounce_pkg holds:
  - N_BTN_DEFAULT=21;
  - the debounce count width function/localparam;
  - typedef btn_vec_t (logic [N_BTN_DEFAULT-1:0]).
- Sub-module pb_debounce_ch: one channel containing synchronizer, counter, level and pulse logic, with the optional repeat counter inside.
- pb_debounce is a generate-for over N_BTN instances of pb_debounce_ch.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and, for the repeat scenario, REPEAT_DELAY=10 and REPEAT_PERIOD=3.
1. Reset with pb_raw=all 1s, hold nrst=0 for 5 cycles -> pb_level=0 and all pulse outputs 0 throughout; after release, pb_level=all 1s exactly 6 edges later, with pb_rise=all 1s for one cycle.
2. Clean press: pb_raw[0] 0->1 held -> pb_rise[0] high for exactly one cycle on edge 6, pb_level[0]=1 from then on; release -> pb_fall[0] pulses on edge 6 after release.
3. Bounce: pb_raw[3] toggles 1,0,1,1,0 (one cycle each), then held 1 -> no pulse during bouncing; a single pb_rise[3] 6 edges after the final stable 1.
4. Glitch: a 3-cycle pulse on pb_raw[7] -> pb_level[7] stays 0, no pb_rise or pb_fall.
5. en low at the third qualifying cycle for 10 cycles -> no level change or pulse while low; after en rises, pb_rise fires 2 edges later.
6. With PB_DEBOUNCE_AUTOREPEAT_EN defined and pb_raw[1] held -> pb_repeat[1] pulses 10 cycles after pb_rise[1], then every 3 cycles; pulses stop as soon as pb_fall[1] fires.
